// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit positions,
// the hex glyph table, polarity helpers and the per-slot state encoding.
package seg7_pkg;

  // Bit positions of each segment inside seg_out.
  localparam int SEG_A = 0;  // top
  localparam int SEG_B = 1;  // upper right
  localparam int SEG_C = 2;  // lower right
  localparam int SEG_D = 3;  // bottom
  localparam int SEG_E = 4;  // lower left
  localparam int SEG_F = 5;  // upper left
  localparam int SEG_G = 6;  // middle

  // Lit-segment patterns (gfedcba, active high) for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Per-slot display phase: BLANK is the anti-ghosting gap, SHOW drives a digit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Inactive level of the seven segment lines for the chosen polarity.
  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  // Inactive level of up to eight digit-select lines; callers slice to width.
  function automatic logic [7:0] dig_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex-nibble to segment-pattern lookup.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  logic [6:0] w_code;

  // Table entries are stored gfedcba; map each segment to its pin bit explicitly.
  always_comb begin
    w_code         = GLYPH[i_nibble];
    o_seg          = '0;
    o_seg[SEG_A]   = w_code[SEG_A];
    o_seg[SEG_B]   = w_code[SEG_B];
    o_seg[SEG_C]   = w_code[SEG_C];
    o_seg[SEG_D]   = w_code[SEG_D];
    o_seg[SEG_E]   = w_code[SEG_E];
    o_seg[SEG_F]   = w_code[SEG_F];
    o_seg[SEG_G]   = w_code[SEG_G];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered value,
// leading-zero blanking, per-digit enable, blank gap and output polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_BITS       = 16,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int                    IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_BITS-1:0]   BLANK_CNT = DIV_BITS'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = seg_off(SEG_ACTIVE_LOW != 0);
  localparam logic [7:0]            DIG_OFF8  = dig_off(DIG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIG_OFF8[NUM_DIGITS-1:0];

  // Scan position
  logic [DIV_BITS-1:0]     r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    w_cnt_wrap;
  logic                    w_frame_wrap;

  // Slot phase
  state_t                  r_state;
  state_t                  w_state_next;

  // Value buffers
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic                    r_pending;

  // Per-digit decode
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic                    w_dark;
  logic [6:0]              w_seg_raw;
  logic                    w_dp_raw;
  logic [NUM_DIGITS-1:0]   w_dig_raw;

  // Registered pins
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_wrap_d;
  logic                    r_frame_start;

  assign w_cnt_wrap   = &r_cnt;
  assign w_frame_wrap = w_cnt_wrap && (r_idx == LAST_IDX);

  // Prescaler counts clocks within a slot; the digit index advances on slot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Slot phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Phase transitions and raw (active-high) pin values for the current position.
  always_comb begin
    w_state_next = r_state;
    w_seg_raw    = '0;
    w_dp_raw     = 1'b0;
    w_dig_raw    = '0;
    case (r_state)
      BLANK: begin
        if ((BLANK_CYCLES == 0) || (r_cnt == BLANK_CNT - 1'b1)) begin
          w_state_next = SHOW;
        end
      end
      SHOW: begin
        if (!w_dark) begin
          w_seg_raw = w_glyph;
          w_dp_raw  = r_active_dp[r_idx];
          for (int k = 0; k < NUM_DIGITS; k++) begin
            w_dig_raw[k] = (r_idx == IDX_W'(k));
          end
        end
        if (w_cnt_wrap && (BLANK_CYCLES != 0)) begin
          w_state_next = BLANK;
        end
      end
      default: w_state_next = BLANK;
    endcase
  end

  // Shadow captures every load; active only changes at a frame boundary so a
  // frame is never torn. A load on the boundary itself goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
    end else if (w_frame_wrap) begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
        r_active_val <= value;
        r_active_dp  <= dp_in;
        r_pending    <= 1'b0;
      end else if (r_pending) begin
        r_active_val <= r_shadow_val;
        r_active_dp  <= r_shadow_dp;
        r_pending    <= 1'b0;
      end
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp_in;
      r_pending    <= 1'b1;
    end
  end

  // w_upper_zero[k] is set when active nibbles NUM_DIGITS-1 down to k are all zero.
  always_comb begin : lz_scan
    logic v_acc;
    v_acc        = 1'b1;
    w_upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_acc           = v_acc & (r_active_val[4*k +: 4] == 4'h0);
      w_upper_zero[k] = v_acc;
    end
  end

  assign w_nibble = r_active_val[4*r_idx +: 4];
  assign w_dark   = !digit_en[r_idx] ||
                    (lz_blank && (r_idx != '0) && w_upper_zero[r_idx]);

  seg7_glyph_rom u_glyph (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Pin registers: polarity applied last, frame_start trails the frame wrap by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_OFF;
      r_dp          <= SEG_OFF[0];
      r_dig         <= DIG_OFF;
      r_wrap_d      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_seg_raw ^ SEG_OFF;
      r_dp          <= w_dp_raw ^ SEG_OFF[0];
      r_dig         <= w_dig_raw ^ DIG_OFF;
      r_wrap_d      <= w_frame_wrap;
      r_frame_start <= r_wrap_d;
    end
  end

  assign seg_out     = r_seg;
  assign dp_out      = r_dp;
  assign dig_sel     = r_dig;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit active-high-segment instance and a
// 3-digit active-low-segment instance share stimulus; a position/buffer model
// predicts every output cycle of both.
module tb_seg7_scan_driver;

  localparam logic [6:0] GLY [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam int SLOT = 8;  // 2^DIV_BITS with DIV_BITS = 3
  localparam int BLNK = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic        load;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fs_a, fs_b;
  logic [3:0] dig_a;
  logic [2:0] dig_b;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DIV_BITS(3), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
    .seg_out(seg_a), .dp_out(dp_a), .dig_sel(dig_a), .frame_start(fs_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(3), .DIV_BITS(3), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .value(value[11:0]), .dp_in(dp_in[2:0]),
    .digit_en(digit_en[2:0]), .lz_blank(lz_blank), .load(load),
    .seg_out(seg_b), .dp_out(dp_b), .dig_sel(dig_b), .frame_start(fs_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position comes from elapsed clocks since reset release; buffers follow the load rules.
  int          m_t      [2];
  logic [15:0] m_act_v  [2];
  logic [15:0] m_sh_v   [2];
  logic [3:0]  m_act_dp [2];
  logic [3:0]  m_sh_dp  [2];
  logic        m_pend   [2];

  function automatic int ndig(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_t[d] = 0; m_act_v[d] = '0; m_sh_v[d] = '0;
      m_act_dp[d] = '0; m_sh_dp[d] = '0; m_pend[d] = 1'b0;
    end
  endtask

  task automatic model_expect(input int d, output logic [6:0] seg, output logic dp,
                              output logic [3:0] dig, output logic fs);
    int n, cnt, idx, nib;
    logic dark, lit;
    n    = ndig(d);
    cnt  = m_t[d] % SLOT;
    idx  = (m_t[d] / SLOT) % n;
    nib  = int'((m_act_v[d] >> (4 * idx)) & 16'hF);
    dark = (digit_en[idx] == 1'b0) ||
           (lz_blank && (idx != 0) && ((m_act_v[d] >> (4 * idx)) == 16'h0));
    lit  = (cnt >= BLNK) && !dark;
    seg  = lit ? GLY[nib] : 7'h00;
    dp   = lit ? m_act_dp[d][idx] : 1'b0;
    dig  = lit ? 4'(1 << idx) : 4'h0;
    if (d == 1) begin
      seg = ~seg;
      dp  = ~dp;
    end
    dig = ~dig;
    fs  = (cnt == 0) && (idx == 0) && (m_t[d] != 0);
  endtask

  task automatic model_advance(input int d);
    int n;
    logic wrap;
    logic [15:0] vmask;
    logic [3:0]  dmask;
    n     = ndig(d);
    wrap  = ((m_t[d] % SLOT) == SLOT - 1) && (((m_t[d] / SLOT) % n) == n - 1);
    vmask = (d == 0) ? 16'hFFFF : 16'h0FFF;
    dmask = (d == 0) ? 4'hF : 4'h7;
    if (load) begin
      if (wrap) begin
        m_act_v[d] = value & vmask; m_act_dp[d] = dp_in & dmask; m_pend[d] = 1'b0;
      end else begin
        m_sh_v[d] = value & vmask; m_sh_dp[d] = dp_in & dmask; m_pend[d] = 1'b1;
      end
    end else if (wrap && m_pend[d]) begin
      m_act_v[d] = m_sh_v[d]; m_act_dp[d] = m_sh_dp[d]; m_pend[d] = 1'b0;
    end
    m_t[d]++;
  endtask

  // ---------------- driver ----------------
  // One clock: predict both DUTs from current inputs, advance the model, compare.
  task automatic step();
    logic [6:0] es [2];
    logic       ed [2];
    logic [3:0] eg [2];
    logic       ef [2];
    for (int d = 0; d < 2; d++) model_expect(d, es[d], ed[d], eg[d], ef[d]);
    for (int d = 0; d < 2; d++) model_advance(d);
    @(posedge clk);
    #1;
    chk("a_seg", seg_a, es[0]);
    chk("a_dp",  dp_a,  ed[0]);
    chk("a_dig", dig_a, eg[0]);
    chk("a_fs",  fs_a,  ef[0]);
    chk("b_seg", seg_b, es[1]);
    chk("b_dp",  dp_b,  ed[1]);
    chk("b_dig", dig_b, eg[1][2:0]);
    chk("b_fs",  fs_b,  ef[1]);
  endtask

  // Step until the next clock edge of DUT d will act on slot position (cnt, idx).
  task automatic goto_pos(input int d, input int cnt, input int idx);
    int n;
    n = ndig(d);
    for (int i = 0; i < 64; i++) begin
      if (((m_t[d] % SLOT) == cnt) && (((m_t[d] / SLOT) % n) == idx)) return;
      step();
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0; value = $urandom; dp_in = $urandom;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [15:0]     v;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic            lz;
    logic [3:0][6:0] seg;   // index = slot
    logic [3:0][3:0] dig;
    logic [3:0]      dpo;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    value = '0; dp_in = '0; digit_en = 4'hF; lz_blank = 1'b0; load = 1'b0;

    tbl[0] = '{16'h12AF, 4'b0100, 4'hF, 1'b0,
               {7'h06, 7'h5B, 7'h77, 7'h71}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b0100};
    tbl[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1,
               {7'h00, 7'h00, 7'h6D, 7'h3F}, {4'hF, 4'hF, 4'hD, 4'hE}, 4'b0000};
    tbl[2] = '{16'h0000, 4'b0001, 4'hF, 1'b1,
               {7'h00, 7'h00, 7'h00, 7'h3F}, {4'hF, 4'hF, 4'hF, 4'hE}, 4'b0001};
    tbl[3] = '{16'h1111, 4'b0010, 4'b1101, 1'b0,
               {7'h06, 7'h06, 7'h00, 7'h06}, {4'h7, 4'hB, 4'hF, 4'hE}, 4'b0000};
    tbl[4] = '{16'h89CD, 4'b1111, 4'hF, 1'b0,
               {7'h7F, 7'h67, 7'h39, 7'h5E}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b1111};
    tbl[5] = '{16'h0E0B, 4'b1001, 4'hF, 1'b1,
               {7'h00, 7'h79, 7'h3F, 7'h7C}, {4'hF, 4'hB, 4'hD, 4'hE}, 4'b0001};
    tbl[6] = '{16'h3456, 4'b0010, 4'h0, 1'b0,
               {7'h00, 7'h00, 7'h00, 7'h00}, {4'hF, 4'hF, 4'hF, 4'hF}, 4'b0000};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_seg", seg_a, 7'h00);
    chk("rst_a_dp",  dp_a,  1'b0);
    chk("rst_a_dig", dig_a, 4'hF);
    chk("rst_a_fs",  fs_a,  1'b0);
    chk("rst_b_seg", seg_b, 7'h7F);
    chk("rst_b_dp",  dp_b,  1'b1);
    chk("rst_b_dig", dig_b, 3'h7);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // First frame_start after release
    for (k = 1; k <= 40; k++) begin
      step();
      if (fs_a) break;
    end
    chk("rst_fs_latency", k, 33);

    // Table-driven frames on DUT A
    for (int r = 0; r < 7; r++) begin
      digit_en = tbl[r].en;
      lz_blank = tbl[r].lz;
      pulse_load(tbl[r].v, tbl[r].dp);
      goto_pos(0, 0, 0);
      for (int s = 0; s < 4; s++) begin
        goto_pos(0, 5, s);
        chk($sformatf("tbl%0d_seg%0d", r, s), seg_a, tbl[r].seg[s]);
        chk($sformatf("tbl%0d_dig%0d", r, s), dig_a, tbl[r].dig[s]);
        chk($sformatf("tbl%0d_dp%0d",  r, s), dp_a,  tbl[r].dpo[s]);
      end
    end

    // Two loads inside one frame: current frame untouched, next frame shows the last
    digit_en = 4'hF; lz_blank = 1'b0;
    pulse_load(16'h0000, 4'h0);
    goto_pos(0, 0, 0);
    goto_pos(0, 2, 1);
    pulse_load(16'h1111, 4'h0);
    step(); step(); step();
    pulse_load(16'h2222, 4'h0);
    goto_pos(0, 5, 3);
    chk("dbl_cur_frame_seg3", seg_a, 7'h3F);
    goto_pos(0, 5, 0);
    chk("dbl_next_seg0", seg_a, 7'h5B);
    goto_pos(0, 5, 2);
    chk("dbl_next_seg2", seg_a, 7'h5B);

    // Load exactly on the frame wrap edge
    goto_pos(0, SLOT - 1, 3);
    pulse_load(16'h7777, 4'h0);
    goto_pos(0, 5, 0);
    chk("wrap_load_seg0", seg_a, 7'h07);
    goto_pos(0, 5, 3);
    chk("wrap_load_seg3", seg_a, 7'h07);

    // 3-digit active-low instance: glyph 8, blank level, frame length
    pulse_load(16'h0888, 4'h0);
    goto_pos(1, 0, 0);
    goto_pos(1, 0, 1);
    goto_pos(1, 5, 1);
    chk("b_glyph8_seg", seg_b, 7'h00);
    chk("b_glyph8_dig", dig_b, 3'b101);
    goto_pos(1, 1, 2);
    chk("b_blank_seg", seg_b, 7'h7F);
    chk("b_blank_dig", dig_b, 3'b111);
    chk("b_blank_dp",  dp_b,  1'b1);
    for (k = 1; k <= 60; k++) begin
      step();
      if (fs_b) break;
    end
    for (k = 1; k <= 60; k++) begin
      step();
      if (fs_b) break;
    end
    chk("b_frame_len", k, 24);

    // Asynchronous reset in the middle of a scan
    pulse_load(16'hABCD, 4'hF);
    goto_pos(0, 0, 0);
    goto_pos(0, 3, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a_seg", seg_a, 7'h00);
    chk("midrst_a_dp",  dp_a,  1'b0);
    chk("midrst_a_dig", dig_a, 4'hF);
    chk("midrst_b_seg", seg_b, 7'h7F);
    chk("midrst_b_dig", dig_b, 3'h7);
    @(posedge clk); #1;
    chk("midrst_hold_a_dig", dig_a, 4'hF);
    rst_n = 1'b1;
    model_reset();
    for (k = 1; k <= 40; k++) begin
      step();
      if (fs_a) break;
    end
    chk("midrst_fs_latency", k, 33);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      lz_blank = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      step();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
